// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: pointer/status controller that runs an external dual-port
// RAM as a circular buffer. No data passes through this block; it only
// produces RAM addresses/enables, a read-valid strobe and FIFO status.
module fifo_mem_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic                  rd_req,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] mem_addr_write,
  output logic                  mem_enable_write,
  output logic [ADDR_WIDTH-1:0] mem_addr_read,
  output logic                  mem_enable_read,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AF_THR  = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THR  = (ADDR_WIDTH+1)'(AE_LEVEL);

  // Pointers carry one extra wrap bit above the RAM address bits so that
  // full and empty can be told apart when the address bits match.
  logic [ADDR_WIDTH:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0] rd_ptr_reg;
  logic                rd_valid_reg;
  logic                overflow_reg;
  logic                underflow_reg;

  logic wr_acc;
  logic rd_acc;

  // Status is derived purely from the registered pointers.
  assign full  = (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign count = wr_ptr_reg - rd_ptr_reg;

  assign almost_full  = (count >= AF_THR);
  assign almost_empty = (count <= AE_THR);

  // Flush wins over both requests; no fall-through on empty and no
  // write-through-read on full, since status comes from the current pointers.
  assign wr_acc = wr_req & ~full  & ~flush;
  assign rd_acc = rd_req & ~empty & ~flush;

  // Enables are forced low while reset is held so the RAM is never touched.
  assign mem_enable_write = wr_acc & rst_n;
  assign mem_enable_read  = rd_acc & rst_n;
  assign mem_addr_write   = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign mem_addr_read    = rd_ptr_reg[ADDR_WIDTH-1:0];

  assign rd_valid  = rd_valid_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // Pointer advance, read-valid pipeline stage and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rd_valid_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= wr_req & full  & ~flush;
      underflow_reg <= rd_req & empty & ~flush;
      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        if (wr_acc) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        end
        if (rd_acc) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
        rd_valid_reg <= rd_acc;
      end
    end
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl: a behavioural RAM is hung off the controller's
// address/enable ports, written words go into a scoreboard queue and are
// compared against the RAM output whenever rd_valid is expected.
module tb_fifo_mem_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] mem_addr_write;
  logic          mem_enable_write;
  logic [AW-1:0] mem_addr_read;
  logic          mem_enable_read;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  fifo_mem_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_req           (wr_req),
    .rd_req           (rd_req),
    .flush            (flush),
    .mem_addr_write   (mem_addr_write),
    .mem_enable_write (mem_enable_write),
    .mem_addr_read    (mem_addr_read),
    .mem_enable_read  (mem_enable_read),
    .rd_valid         (rd_valid),
    .full             (full),
    .empty            (empty),
    .almost_full      (almost_full),
    .almost_empty     (almost_empty),
    .count            (count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered read.
  logic [7:0] ram [DEPTH];
  logic [7:0] ram_q;
  logic [7:0] wdata = 8'h00;

  always @(posedge clk) begin
    if (mem_enable_write) ram[mem_addr_write] <= wdata;
    if (mem_enable_read)  ram_q <= ram[mem_addr_read];
  end

  int         checks = 0;
  int         errors = 0;
  int         m_cnt = 0;
  int         m_waddr = 0;
  int         m_raddr = 0;
  int         wraps = 0;
  logic       exp_rv = 1'b0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] data_ctr = 8'h01;
  logic [7:0] sb [$];

  // One clock of stimulus; called right after a posedge (+1).
  task automatic step(input logic w, input logic r, input logic f);
    logic       ew, er, ov, un;
    logic [6:0] st_exp, st_got;
    wr_req = w; rd_req = r; flush = f; wdata = data_ctr;
    ew = w && (m_cnt != DEPTH) && !f;
    er = r && (m_cnt != 0) && !f;
    ov = w && (m_cnt == DEPTH) && !f;
    un = r && (m_cnt == 0) && !f;
    @(negedge clk);
    checks++;
    if (mem_enable_write !== ew) begin
      errors++; $display("FAIL en_write got %b exp %b", mem_enable_write, ew);
    end
    checks++;
    if (mem_enable_read !== er) begin
      errors++; $display("FAIL en_read got %b exp %b", mem_enable_read, er);
    end
    if (ew) begin
      checks++;
      if (mem_addr_write !== AW'(m_waddr)) begin
        errors++; $display("FAIL addr_write got %0d exp %0d", mem_addr_write, m_waddr);
      end
      sb.push_back(wdata);
    end
    if (er) begin
      checks++;
      if (mem_addr_read !== AW'(m_raddr)) begin
        errors++; $display("FAIL addr_read got %0d exp %0d", mem_addr_read, m_raddr);
      end
      if (sb.size() == 0) begin
        errors++; $display("FAIL scoreboard_underrun got read exp none");
      end else begin
        exp_rdata = sb.pop_front();
      end
    end
    @(posedge clk); #1;
    if (f) begin
      m_cnt = 0; m_waddr = 0; m_raddr = 0; sb.delete();
    end else begin
      if (ew) begin
        m_waddr = (m_waddr + 1) % DEPTH; m_cnt++;
        if (m_waddr == 0) wraps++;
      end
      if (er) begin
        m_raddr = (m_raddr + 1) % DEPTH; m_cnt--;
      end
    end
    exp_rv = er;
    data_ctr = data_ctr + 8'd1;
    $display("txn w=%b r=%b f=%b acc_w=%b acc_r=%b count=%0d rd_valid=%b q=%02h",
             w, r, f, ew, er, count, rd_valid, ram_q);
    checks++;
    if (count !== 5'(m_cnt)) begin
      errors++; $display("FAIL count got %0d exp %0d", count, m_cnt);
    end
    st_exp = {m_cnt == DEPTH, m_cnt == 0, m_cnt >= AF, m_cnt <= AE, exp_rv, ov, un};
    st_got = {full, empty, almost_full, almost_empty, rd_valid, overflow, underflow};
    checks++;
    if (st_got !== st_exp) begin
      errors++; $display("FAIL status{full,empty,af,ae,rv,ov,un} got %b exp %b", st_got, st_exp);
    end
    if (exp_rv) begin
      checks++;
      if (ram_q !== exp_rdata) begin
        errors++; $display("FAIL rd_data got %02h exp %02h", ram_q, exp_rdata);
      end
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_waddr = 0; m_raddr = 0; sb.delete(); exp_rv = 1'b0;
  endtask

  task automatic test_reset();
    wr_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_enable_write !== 1'b0) begin
      errors++; $display("FAIL reset_en_write got %b exp 0", mem_enable_write);
    end
    wr_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow} !==
        {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state got count=%0d f=%b e=%b af=%b ae=%b rv=%b ov=%b un=%b exp 0,0,1,0,1,0,0,0",
                         count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL fill got full=%b count=%0d exp 1 16", full, count);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++; $display("FAIL overflow got ov=%b count=%0d exp 1 16", overflow, count);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_pulse got %b exp 0", overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL drain got empty=%b exp 1", empty);
    end
  endtask

  task automatic test_underflow_with_write();
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL underflow_wr got un=%b count=%0d empty=%b exp 1 1 0",
                         underflow, count, empty);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (count !== 5'd5 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL simultaneous got count=%0d rv=%b exp 5 1", count, rd_valid);
    end
  endtask

  task automatic test_wrap();
    int w0;
    w0 = wraps;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (full !== 1'b0 || empty !== 1'b0) begin
        errors++; $display("FAIL wrap_status got full=%b empty=%b exp 0 0", full, empty);
      end
    end
    checks++;
    if (wraps - w0 < 2) begin
      errors++; $display("FAIL wrap_count got %0d exp >=2", wraps - w0);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (count !== 5'd7) begin
      errors++; $display("FAIL flush_setup got count=%0d exp 7", count);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL flush got count=%0d empty=%b exp 0 1", count, empty);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    wr_req = 1'b1; rd_req = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count, full, empty, almost_full, almost_empty, rd_valid, overflow, underflow,
         mem_enable_write, mem_enable_read} !==
        {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL mid_reset got count=%0d f=%b e=%b af=%b ae=%b rv=%b ov=%b un=%b ew=%b er=%b",
                         count, full, empty, almost_full, almost_empty, rd_valid, overflow,
                         underflow, mem_enable_write, mem_enable_read);
    end
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_back got empty=%b rv=%b exp 1 0", empty, rd_valid);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow_with_write();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
